// File: rtl/dft_index_sequencer.sv
// Index sequencer for the DFT MAC datapath: walks (k, n), emits twiddle indices and bin/calc strobes.
// Optional build macro DFT_SEQ_HALF_SPECTRUM_EN restricts the bins to 0..N/2.
module dft_index_sequencer #(
  parameter int AW       = 12,
  parameter int PIPE_LAT = 3
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          ce,
  input  logic          start,
  input  logic [AW-1:0] sample_num,
  input  logic          ready,
  output logic          busy,
  output logic [1:0]    state,
  output logic          step_valid,
  output logic [AW-1:0] n_idx,
  output logic [AW-1:0] k_idx,
  output logic [AW-1:0] tw_idx,
  output logic          acc_clear,
  output logic          acc_last,
  output logic          bin_valid,
  output logic [AW-1:0] bin_k,
  output logic          calc_end,
  output logic          cfg_err
);

  localparam logic [AW-1:0] ONE = AW'(1);

  // state   | meaning
  // S_IDLE  | waiting for start; 2'b11 also decodes here
  // S_RUN   | issuing (k, n) steps to the datapath
  // S_DRAIN | waiting PIPE_LAT ce-cycles for the final bin
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] num_q;
  logic [AW-1:0] nmax_q;
  logic [AW-1:0] kmax_q;
  logic [AW-1:0] kmax_init;
  logic [3:0]    drain_cnt;
  logic          accept;
  logic          n_wrap;
  logic          k_done;
  logic          start_ok;
  logic          start_bad;
  logic [AW:0]   tw_sum;
  logic [AW-1:0] tw_next;
  logic          push_bin;

  logic [PIPE_LAT:0] dl_v;
  logic [AW-1:0]     dl_k [0:PIPE_LAT];

`ifdef DFT_SEQ_HALF_SPECTRUM_EN
  assign kmax_init = sample_num >> 1;
`else
  assign kmax_init = sample_num - ONE;
`endif

  // tw stays below N and k < N, so one conditional subtract keeps tw = (n*k) mod N
  always_comb begin
    accept   = step_valid && ready;
    n_wrap   = (n_idx == nmax_q);
    k_done   = (k_idx == kmax_q);
    tw_sum   = {1'b0, tw_idx} + {1'b0, k_idx};
    tw_next  = (tw_sum >= {1'b0, num_q}) ? (tw_sum[AW-1:0] - num_q) : tw_sum[AW-1:0];
    push_bin = accept && acc_last;
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state_q)
      S_RUN: begin
        if (accept && n_wrap && k_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (calc_end) state_d = S_IDLE;
      end
      default: begin
        if (start) begin
          if (sample_num < AW'(2)) begin
            start_bad = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = S_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      nmax_q     <= '0;
      kmax_q     <= '0;
      n_idx      <= '0;
      k_idx      <= '0;
      tw_idx     <= '0;
      step_valid <= 1'b0;
      acc_clear  <= 1'b0;
      acc_last   <= 1'b0;
      drain_cnt  <= '0;
      calc_end   <= 1'b0;
      cfg_err    <= 1'b0;
      dl_v       <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) dl_k[i] <= '0;
    end else if (ce) begin
      state_q  <= state_d;
      cfg_err  <= start_bad;
      calc_end <= 1'b0;

      if (start_ok) begin
        num_q      <= sample_num;
        nmax_q     <= sample_num - ONE;
        kmax_q     <= kmax_init;
        n_idx      <= '0;
        k_idx      <= '0;
        tw_idx     <= '0;
        step_valid <= 1'b1;
        acc_clear  <= 1'b1;
        acc_last   <= 1'b0;
      end else if (state_q == S_RUN && accept) begin
        if (!n_wrap) begin
          n_idx     <= n_idx + ONE;
          tw_idx    <= tw_next;
          acc_clear <= 1'b0;
          acc_last  <= ((n_idx + ONE) == nmax_q);
        end else if (!k_done) begin
          n_idx     <= '0;
          k_idx     <= k_idx + ONE;
          tw_idx    <= '0;
          acc_clear <= 1'b1;
          acc_last  <= 1'b0;
        end else begin
          step_valid <= 1'b0;
          acc_clear  <= 1'b0;
          acc_last   <= 1'b0;
          drain_cnt  <= 4'(PIPE_LAT - 1);
        end
      end

      if (state_q == S_DRAIN && !calc_end) begin
        if (drain_cnt == 4'd0) calc_end <= 1'b1;
        else drain_cnt <= drain_cnt - 4'd1;
      end

      // bubbles are pushed on every ce-cycle without an accepted last step
      dl_v[0] <= push_bin;
      dl_k[0] <= push_bin ? k_idx : '0;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_k[i] <= dl_k[i-1];
      end
    end
  end

  assign bin_valid = dl_v[PIPE_LAT];
  assign bin_k     = dl_k[PIPE_LAT];
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign state     = state_q;

endmodule

// File: tb/tb_dft_index_sequencer.sv
// Scoreboard bench for dft_index_sequencer: expected steps/bins are queued at start and
// popped by a negedge monitor on each acceptance or bin strobe.
module tb_dft_index_sequencer;
  localparam int AW = 12;
  localparam int PL = 3;
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          ce = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] sample_num = '0;
  logic          ready = 1'b0;
  logic          busy;
  logic [1:0]    state;
  logic          step_valid;
  logic [AW-1:0] n_idx, k_idx, tw_idx, bin_k;
  logic          acc_clear, acc_last, bin_valid, calc_end, cfg_err;

  dft_index_sequencer #(.AW(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .nrst(nrst), .ce(ce), .start(start), .sample_num(sample_num),
    .ready(ready), .busy(busy), .state(state), .step_valid(step_valid),
    .n_idx(n_idx), .k_idx(k_idx), .tw_idx(tw_idx), .acc_clear(acc_clear),
    .acc_last(acc_last), .bin_valid(bin_valid), .bin_k(bin_k),
    .calc_end(calc_end), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] n;
    logic [AW-1:0] k;
    logic [AW-1:0] tw;
    logic          clr;
    logic          last;
  } step_t;

  step_t         exp_q[$];
  logic [AW-1:0] bin_q[$];
  int total = 0;
  int bad = 0;

  // hand-computed twiddle indices for N=4, row = k, column = n
  int tw4 [16] = '{0, 0, 0, 0,  0, 1, 2, 3,  0, 2, 0, 2,  0, 3, 2, 1};

  logic [56:0] outs, p_outs;
  logic [38:0] hold_v, p_hold;
  assign outs   = {busy, state, step_valid, n_idx, k_idx, tw_idx, acc_clear, acc_last,
                   bin_valid, bin_k, calc_end, cfg_err};
  assign hold_v = {step_valid, n_idx, k_idx, tw_idx, acc_clear, acc_last};

  int ce_edge = 0;
  int acc_cnt = 0;
  int last_acc_edge = 0;
  int calc_cnt = 0;
  int cfg_cnt = 0;
  int sv_seen = 0;
  logic p_ce = 1'b0, p_nrst = 1'b0, p_ready = 1'b0, p_sv = 1'b0;
  logic p_bv = 1'b0, p_ce_out = 1'b0, p_cfg = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // monitor: observes results of the previous edge, then inputs for the coming edge
  always @(negedge clk) begin
    step_t a;
    logic  pe_ok;
    pe_ok = p_ce && p_nrst;
    if (p_nrst && !p_ce) chk("freeze", 64'(outs), 64'(p_outs));
    if (pe_ok && p_sv && !p_ready) chk("hold", 64'(hold_v), 64'(p_hold));
    if (nrst && ce && ready && step_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_step", 64'(1), 64'(0));
      end else begin
        a = exp_q.pop_front();
        chk("step", 64'({n_idx, k_idx, tw_idx, acc_clear, acc_last}), 64'(a));
      end
      acc_cnt++;
      last_acc_edge = ce_edge + 1;
    end
    if (bin_valid && (pe_ok || !p_bv)) begin
      if (bin_q.size() == 0) chk("extra_bin", 64'(1), 64'(0));
      else chk("bin_k", 64'(bin_k), 64'(bin_q.pop_front()));
    end
    if (calc_end && (pe_ok || !p_ce_out)) begin
      calc_cnt++;
      chk("calc_lat", 64'(ce_edge - last_acc_edge), 64'(PL));
      chk("calc_bin", 64'(bin_valid), 64'(1));
    end
    if (cfg_err && (pe_ok || !p_cfg)) cfg_cnt++;
    if (step_valid) sv_seen++;
    p_outs   = outs;
    p_hold   = hold_v;
    p_ce     = ce;
    p_nrst   = nrst;
    p_ready  = ready;
    p_sv     = step_valid;
    p_bv     = bin_valid;
    p_ce_out = calc_end;
    p_cfg    = cfg_err;
    if (ce && nrst) ce_edge++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int nn, output int steps);
    int    kmax;
    step_t s;
    kmax  = HALF ? nn / 2 : nn - 1;
    steps = 0;
    for (int k = 0; k <= kmax; k++) begin
      for (int n = 0; n < nn; n++) begin
        s.n    = AW'(n);
        s.k    = AW'(k);
        s.tw   = (nn == 4) ? AW'(tw4[k*4+n]) : AW'((n * k) % nn);
        s.clr  = (n == 0);
        s.last = (n == nn - 1);
        exp_q.push_back(s);
        if (n == nn - 1) bin_q.push_back(AW'(k));
        steps++;
      end
    end
  endtask

  task automatic start_run(input int nn);
    sample_num = AW'(nn);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_end(input int rmode, input bit mid_start, input bit gap, input int budget);
    int c0, c;
    c0 = calc_cnt;
    c  = 0;
    while (calc_cnt == c0 && c < budget) begin
      ready = (rmode == 0) || (c % 3 == 0);
      ce    = !(gap && c >= 10 && c < 15);
      start = mid_start && (c == 5);
      if (mid_start && c == 5) sample_num = AW'(7);
      tick();
      c++;
    end
    start = 1'b0;
    ce    = 1'b1;
    ready = 1'b1;
    chk("calc_seen", 64'(calc_cnt - c0), 64'(1));
    chk("idle_after", 64'({busy, state}), 64'(0));
  endtask

  task automatic end_checks(input string tag, input int steps, input int a0, input int c0);
    chk({tag, "_steps"}, 64'(acc_cnt - a0), 64'(steps));
    chk({tag, "_steps_left"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_bins_left"}, 64'(bin_q.size()), 64'(0));
    repeat (10) tick();
    chk({tag, "_single_calc"}, 64'(calc_cnt - c0), 64'(1));
  endtask

  initial begin
    int steps, a0, c0, s0, st_edge, w;
    repeat (3) tick();
    chk("reset_outs", 64'(outs), 64'(0));
    nrst = 1'b1;
    ce   = 1'b1;
    tick();
    chk("idle_outs", 64'(outs), 64'(0));

    // full run, ready held high
    push_run(4, steps);
    chk("n4_steps_model", 64'(steps), HALF ? 64'(12) : 64'(16));
    a0 = acc_cnt; c0 = calc_cnt; ready = 1'b1;
    start_run(4);
    st_edge = ce_edge;
    chk("start_state", 64'({busy, state, step_valid, acc_clear, n_idx, k_idx, tw_idx}),
        64'({1'b1, 2'b01, 1'b1, 1'b1, {(3*AW){1'b0}}}));
    run_to_end(0, 1'b0, 1'b0, 200);
    chk("throughput", 64'(last_acc_edge - st_edge), 64'(steps));
    end_checks("ready1", steps, a0, c0);

    // backpressure 1,0,0 pattern
    push_run(4, steps);
    a0 = acc_cnt; c0 = calc_cnt;
    start_run(4);
    run_to_end(1, 1'b0, 1'b0, 400);
    end_checks("bp", steps, a0, c0);

    // start and sample_num change mid-run are ignored
    push_run(4, steps);
    a0 = acc_cnt; c0 = calc_cnt;
    start_run(4);
    run_to_end(0, 1'b1, 1'b0, 200);
    end_checks("midstart", steps, a0, c0);

    // rejected lengths
    for (int nn = 1; nn >= 0; nn--) begin
      c0 = cfg_cnt; s0 = sv_seen;
      start_run(nn);
      chk("cfg_err", 64'(cfg_err), 64'(1));
      chk("cfg_busy", 64'(busy), 64'(0));
      repeat (5) tick();
      chk("cfg_once", 64'(cfg_cnt - c0), 64'(1));
      chk("cfg_nostep", 64'(sv_seen - s0), 64'(0));
    end

    // reset mid-run after 7 steps
    push_run(4, steps);
    a0 = acc_cnt; c0 = calc_cnt;
    start_run(4);
    w = 0;
    while (acc_cnt - a0 < 7 && w < 50) begin
      tick();
      w++;
    end
    chk("reached_step7", 64'(acc_cnt - a0), 64'(7));
    nrst = 1'b0;
    tick();
    chk("rst_outs", 64'(outs), 64'(0));
    nrst = 1'b1;
    exp_q.delete();
    bin_q.delete();
    repeat (10) tick();
    chk("rst_nocalc", 64'(calc_cnt - c0), 64'(0));

    push_run(4, steps);
    a0 = acc_cnt; c0 = calc_cnt;
    start_run(4);
    run_to_end(0, 1'b0, 1'b0, 200);
    end_checks("post_rst", steps, a0, c0);

    // N=8 with a 5-cycle ce gap mid-run
    push_run(8, steps);
    a0 = acc_cnt; c0 = calc_cnt;
    start_run(8);
    run_to_end(0, 1'b0, 1'b1, 300);
    chk("n8_steps", 64'(acc_cnt - a0), HALF ? 64'(40) : 64'(64));
    end_checks("n8", steps, a0, c0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dft_index_sequencer.md
# dft_index_sequencer

Sequencer that drives the DFT multiply-accumulate datapath once the sample cache is loaded. It walks the bin index k and the sample index n over all required (k, n) pairs and emits cache read addresses and twiddle-ROM indices. It issues accumulator clear and last strobes and reports per-bin completion and end of calculation. It sits between the top-level control FSM, which pulses `start` and consumes `calc_end`, and the cache/twiddle/MAC datapath.

## Interface
Parameters:
- `AW`, 12, index/address width; max transform length 2^AW-1.
- `PIPE_LAT`, 3, MAC datapath latency in ce-cycles from step acceptance to accumulator result; legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset, synchronous, active-low.
- `ce`  in  1  clock enable; all state, including the delay line, is frozen when low.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `sample_num`  in  AW  transform length N; latched at start.
- `ready`  in  1  datapath accepts the current step.
- `busy`  out  1  high in RUN and DRAIN.
- `state`  out  2  IDLE=00, RUN=01, DRAIN=10; 11 unused and decodes to IDLE.
- `step_valid`  out  1  n_idx/k_idx/tw_idx/acc_clear/acc_last are valid.
- `n_idx`  out  AW  sample cache read address.
- `k_idx`  out  AW  bin index of the current step.
- `tw_idx`  out  AW  (n*k) mod N, twiddle ROM address.
- `acc_clear`  out  1  first step of a bin (n==0).
- `acc_last`  out  1  last step of a bin (n==N-1).
- `bin_valid`  out  1  one-cycle pulse; the accumulator holds the finished bin.
- `bin_k`  out  AW  bin index qualifying bin_valid.
- `calc_end`  out  1  one-cycle pulse; the final bin is complete.
- `cfg_err`  out  1  one-cycle pulse; start was rejected because N<2.

## Operation
- Reset: state IDLE; all outputs 0; delay line cleared.
- A step is accepted when `step_valid && ready && ce`. Step outputs hold stable while not accepted.
- IDLE: on `start && ce`:
  - If `sample_num < 2`: pulse `cfg_err` next cycle and stay in IDLE.
  - Otherwise: latch N, set KMAX=N-1, load n=k=tw=0, assert `step_valid` and `acc_clear`, go to RUN.
- RUN: on acceptance, advance the step.
  - If n<N-1: n+=1. Compute t=tw+k in AW+1 bits; tw = t>=N ? t-N : t. A single subtract is sufficient because tw<N and k<N.
  - If n==N-1 and k<KMAX: n=0, k+=1, tw=0.
  - If n==N-1 and k==KMAX: drop `step_valid` and go to DRAIN.
- `acc_clear` = (n==0). `acc_last` = (n==N-1). Both are registered alongside the indices.
- Delay line: each accepted step pushes {acc_last, k_idx}. Any other ce-cycle pushes a bubble. The delay line shifts every ce-cycle regardless of `ready`. Its output at depth PIPE_LAT drives `bin_valid`/`bin_k`.
- DRAIN: count PIPE_LAT ce-cycles after the final acceptance. `calc_end` pulses in the same cycle as the final `bin_valid`. Then go to IDLE and drop `busy`.
- `start` is ignored while busy. A change on `sample_num` during a run has no effect.
- nrst low mid-run forces the reset state. No `calc_end` is produced and in-flight bins are discarded.
- Total accepted steps = N*(KMAX+1).

## Timing
- `start` sampled at edge t → `busy`, `step_valid`, and `acc_clear` are high after edge t, with n=k=tw=0.
- With `ready` held high, one step is accepted per cycle, with no bubble at the bin boundary.
- Final step accepted at edge a → `bin_valid` for the last bin and `calc_end` assert after edge a+PIPE_LAT, assuming ce is continuously high. `busy` is low from the following cycle.
- Minimum start-to-start interval: N*(KMAX+1)+PIPE_LAT+2 cycles.
- `cfg_err` asserts the cycle after the rejected start.

## Configuration
- `DFT_SEQ_HALF_SPECTRUM_EN`:
  - Defined: KMAX = N>>1, so bins 0..floor(N/2) are computed for real-input symmetry. Steps = N*(floor(N/2)+1).
  - Undefined: KMAX = N-1, the full spectrum.
  - All other behaviour is identical.

## Test plan
- Full spectrum, N=4, ready=1, ce=1:
  - 16 consecutive steps are accepted.
  - tw sequence: k=1 → 0,1,2,3; k=2 → 0,2,0,2; k=3 → 0,3,2,1.
  - bin_valid pulses with bin_k=0..3.
  - calc_end arrives PIPE_LAT cycles after the 16th acceptance.
- Backpressure, N=4, ready toggling 1,0,0,1,…: indices hold during ready=0, the same 16 (n,k,tw) tuples appear in order, and calc_end is delayed accordingly.
- N=1 or N=0 start → cfg_err pulses once, busy stays 0, and no step_valid is produced.
- start pulsed mid-run, N=4 → ignored; the step count stays 16 and there is a single calc_end.
- nrst low at step 7 of N=4 → all outputs 0 and state=00 the next cycle, with no calc_end. A subsequent start runs cleanly.
- `DFT_SEQ_HALF_SPECTRUM_EN` defined, N=8 → 40 steps, bins 0..4, and k=3 tw sequence 0,3,6,1,4,7,2,5. With ce low for 5 cycles mid-run, all outputs freeze and the run completes unchanged.
